// File: rtl/reorder_commit_unit.sv
// Reorder/commit unit: tracks in-flight instructions split into micro-ops
// over several in-order execution queues and retires them in program order,
// up to COMMIT_WIDTH per cycle, through a valid/ready commit port.
module reorder_commit_unit #(
    parameter int NUM_QUEUES   = 4,
    parameter int DEPTH        = 8,
    parameter int UOP_DEPTH    = 8,
    parameter int ID_WIDTH     = 3,
    parameter int COMMIT_WIDTH = 2
) (
    input  logic                             clk_i,
    input  logic                             arsn_i,
    input  logic                             flush_i,
    input  logic                             uop_push_i,
    input  logic [$clog2(NUM_QUEUES)-1:0]    uop_sel_i,
    input  logic                             uop_last_i,
    input  logic [ID_WIDTH-1:0]              uop_id_i,
    input  logic [NUM_QUEUES-1:0]            queues_done_i,
    output logic                             full_o,
    output logic [$clog2(DEPTH):0]           count_o,
    output logic [COMMIT_WIDTH-1:0]          commit_valid_o,
    output logic [COMMIT_WIDTH*ID_WIDTH-1:0] commit_id_o,
    input  logic                             commit_ready_i,
    output logic                             overflow_o,
    output logic                             underflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(UOP_DEPTH);
    localparam int CW = $clog2(NUM_QUEUES * UOP_DEPTH + 1);

    // Instruction table with wrap-bit pointers; open_q marks a tail entry
    // that already holds micro-ops but has not been closed yet.
    logic [PW:0]          head_q, head_d, tail_q, tail_d;
    logic                 open_q, open_d;
    logic [ID_WIDTH-1:0]  id_q [DEPTH];
    logic [ID_WIDTH-1:0]  id_d [DEPTH];
    logic [DEPTH-1:0]     closed_q, closed_d;
    logic [CW-1:0]        pend_q [DEPTH];
    logic [CW-1:0]        pend_d [DEPTH];

    // Per-queue FIFOs of table indices, one per outstanding micro-op.
    logic [PW-1:0]        tag_mem_q [NUM_QUEUES][UOP_DEPTH];
    logic [PW-1:0]        tag_mem_d [NUM_QUEUES][UOP_DEPTH];
    logic [TW:0]          tag_wr_q [NUM_QUEUES];
    logic [TW:0]          tag_wr_d [NUM_QUEUES];
    logic [TW:0]          tag_rd_q [NUM_QUEUES];
    logic [TW:0]          tag_rd_d [NUM_QUEUES];

    logic                 overflow_q, overflow_d, underflow_q, underflow_d;

    // Status derived from registered state only.
    logic [PW:0]                     used_s, count_s, retire_n_s;
    logic                            full_s, push_ok_s, retire_s;
    logic [NUM_QUEUES-1:0]           tag_empty_s, pop_s;
    logic [PW-1:0]                   tag_head_s [NUM_QUEUES];
    logic [COMMIT_WIDTH-1:0]         valid_s;
    logic [COMMIT_WIDTH*ID_WIDTH-1:0] cid_s;

    // Occupancy, fullness, queue pops and contiguous commit lanes.
    always_comb begin
        logic          lane_ok;
        logic [PW-1:0] lane_idx;
        used_s     = tail_q - head_q;
        count_s    = used_s + (PW+1)'(open_q);
        full_s     = (count_s == (PW+1)'(DEPTH));
        lane_ok    = 1'b1;
        lane_idx   = '0;
        valid_s    = '0;
        cid_s      = '0;
        retire_n_s = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            tag_empty_s[q] = (tag_wr_q[q] == tag_rd_q[q]);
            full_s = full_s | ((tag_wr_q[q][TW] != tag_rd_q[q][TW]) &&
                               (tag_wr_q[q][TW-1:0] == tag_rd_q[q][TW-1:0]));
            tag_head_s[q] = tag_mem_q[q][tag_rd_q[q][TW-1:0]];
            // A tag pushed this cycle is not yet visible to a completion.
            pop_s[q] = queues_done_i[q] & ~tag_empty_s[q];
        end
        push_ok_s = uop_push_i & ~full_s;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            lane_idx = head_q[PW-1:0] + PW'(k);
            if (lane_ok && ((PW+1)'(k) < used_s) && closed_q[lane_idx] &&
                (pend_q[lane_idx] == '0)) begin
                valid_s[k] = 1'b1;
                cid_s[k*ID_WIDTH +: ID_WIDTH] = id_q[lane_idx];
                retire_n_s = retire_n_s + (PW+1)'(1);
            end else begin
                lane_ok = 1'b0;
            end
        end
        retire_s = commit_ready_i & valid_s[0];
    end

    // Next-state: flush wins; otherwise retire, completions and dispatch merge.
    always_comb begin
        logic [CW-1:0] dec_v;
        logic [PW-1:0] tail_idx;
        logic [PW-1:0] ret_idx;
        head_d      = head_q;
        tail_d      = tail_q;
        open_d      = open_q;
        id_d        = id_q;
        closed_d    = closed_q;
        pend_d      = pend_q;
        tag_mem_d   = tag_mem_q;
        tag_wr_d    = tag_wr_q;
        tag_rd_d    = tag_rd_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        dec_v       = '0;
        tail_idx    = tail_q[PW-1:0];
        ret_idx     = '0;
        if (flush_i) begin
            head_d      = '0;
            tail_d      = '0;
            open_d      = 1'b0;
            closed_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            for (int e = 0; e < DEPTH; e++) begin
                id_d[e]   = '0;
                pend_d[e] = '0;
            end
            for (int q = 0; q < NUM_QUEUES; q++) begin
                tag_wr_d[q] = '0;
                tag_rd_d[q] = '0;
                for (int t = 0; t < UOP_DEPTH; t++) begin
                    tag_mem_d[q][t] = '0;
                end
            end
        end else begin
            overflow_d  = overflow_q | (uop_push_i & full_s);
            underflow_d = underflow_q | (|(queues_done_i & tag_empty_s));
            if (retire_s) begin
                head_d = head_q + retire_n_s;
                for (int k = 0; k < COMMIT_WIDTH; k++) begin
                    ret_idx           = head_q[PW-1:0] + PW'(k);
                    closed_d[ret_idx] = closed_d[ret_idx] & ~valid_s[k];
                    id_d[ret_idx]     = valid_s[k] ? '0 : id_d[ret_idx];
                end
            end else begin
                head_d = head_q;
            end
            for (int q = 0; q < NUM_QUEUES; q++) begin
                tag_rd_d[q] = tag_rd_q[q] + (TW+1)'(pop_s[q]);
            end
            if (push_ok_s) begin
                tag_mem_d[uop_sel_i][tag_wr_q[uop_sel_i][TW-1:0]] = tail_idx;
                tag_wr_d[uop_sel_i] = tag_wr_q[uop_sel_i] + (TW+1)'(1);
                if (uop_last_i) begin
                    id_d[tail_idx]     = uop_id_i;
                    closed_d[tail_idx] = 1'b1;
                    tail_d             = tail_q + (PW+1)'(1);
                    open_d             = 1'b0;
                end else begin
                    open_d = 1'b1;
                end
            end else begin
                open_d = open_q;
            end
            // Net every same-cycle completion against any dispatch increment.
            for (int e = 0; e < DEPTH; e++) begin
                dec_v = '0;
                for (int q = 0; q < NUM_QUEUES; q++) begin
                    dec_v = dec_v + CW'(pop_s[q] && (tag_head_s[q] == PW'(e)));
                end
                pend_d[e] = pend_q[e] + CW'(push_ok_s && (tail_idx == PW'(e))) - dec_v;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge arsn_i) begin
        if (!arsn_i) begin
            head_q      <= '0;
            tail_q      <= '0;
            open_q      <= 1'b0;
            closed_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            for (int e = 0; e < DEPTH; e++) begin
                id_q[e]   <= '0;
                pend_q[e] <= '0;
            end
            for (int q = 0; q < NUM_QUEUES; q++) begin
                tag_wr_q[q] <= '0;
                tag_rd_q[q] <= '0;
                for (int t = 0; t < UOP_DEPTH; t++) begin
                    tag_mem_q[q][t] <= '0;
                end
            end
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            open_q      <= open_d;
            closed_q    <= closed_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            id_q        <= id_d;
            pend_q      <= pend_d;
            tag_wr_q    <= tag_wr_d;
            tag_rd_q    <= tag_rd_d;
            tag_mem_q   <= tag_mem_d;
        end
    end

    assign full_o         = full_s;
    assign count_o        = count_s;
    assign commit_valid_o = valid_s;
    assign commit_id_o    = cid_s;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule

// File: doc/reorder_commit_unit.md
Name: reorder_commit_unit

Overview:
Parametrised successor to the single-ID re-order logic. It tracks in-flight instructions, each split into one or more micro-ops dispatched to NUM_QUEUES in-order execution queues. Queues may complete out of order with respect to one another. Instructions retire strictly in program order, up to COMMIT_WIDTH per cycle, through a valid/ready commit port. Adds flush, occupancy reporting and sticky protocol-error flags, none of which the previous generation had.

Parameters:
NUM_QUEUES, 4, number of execution queues
DEPTH, 8, instruction table entries (power of two)
UOP_DEPTH, 8, outstanding micro-op tags per queue (power of two)
ID_WIDTH, 3, width of external instruction ID
COMMIT_WIDTH, 2, max instructions retired per cycle (1..DEPTH)

Ports:
clk_i  in  1  clock
arsn_i  in  1  asynchronous active-low reset
flush_i  in  1  synchronous clear of all tracking state
uop_push_i  in  1  dispatch one micro-op
uop_sel_i  in  $clog2(NUM_QUEUES)  target queue of micro-op
uop_last_i  in  1  micro-op closes current instruction
uop_id_i  in  ID_WIDTH  instruction ID, sampled with uop_last_i
queues_done_i  in  NUM_QUEUES  per-queue completion pulse, oldest outstanding micro-op of that queue
full_o  out  1  dispatch not accepted this cycle
count_o  out  $clog2(DEPTH)+1  occupied instruction entries (open entry included)
commit_valid_o  out  COMMIT_WIDTH  lane k holds a retiring instruction
commit_id_o  out  COMMIT_WIDTH*ID_WIDTH  lane k ID at bits [k*ID_WIDTH +: ID_WIDTH]
commit_ready_i  in  1  consumer accepts all valid lanes this cycle
overflow_o  out  1  sticky: push while full
underflow_o  out  1  sticky: completion on queue with no outstanding tag

Behaviour:
- Reset (arsn_i low, asynchronous): all outputs 0; head = tail = 0; all pending counts, tag FIFOs, closed bits and sticky flags cleared.
- Instruction table: circular buffer, head/tail pointers with wrap bit. Per entry: ID, closed bit, pending count of width $clog2(NUM_QUEUES*UOP_DEPTH+1).
- Open entry = tail entry. It becomes occupied on its first micro-op; count_o includes it from that cycle.
- Dispatch (uop_push_i & ~full_o):
  - Push tail index into tag FIFO of queue uop_sel_i.
  - Increment pending count of the tail entry.
  - If uop_last_i: store uop_id_i, set closed bit, advance tail by 1 (wraps at DEPTH).
- full_o = (count_o == DEPTH) | tag FIFO of any queue full. This is deliberately conservative and independent of uop_sel_i.
- Push while full_o: dropped, overflow_o set until reset/flush.
- Completion, queues_done_i[q]:
  - Pops head of queue q tag FIFO and decrements pending count of the tagged entry.
  - Several queues naming the same entry in one cycle decrement it by the number of such queues.
  - A same-cycle dispatch increment to that entry is netted against the decrement.
- Completion on an empty tag FIFO: ignored, underflow_o set (sticky). A tag pushed in the same cycle does not count as present.
- Done entry = closed & pending == 0.
- Commit lanes, combinational from registered state:
  - Lane k valid iff entries head..head+k are all done and occupied.
  - Lanes are contiguous: lane k valid implies lanes 0..k-1 valid.
  - Lane k carries ID of entry head+k.
- Retire: when commit_ready_i and commit_valid_o[0], head advances by popcount(commit_valid_o) and those entries are cleared. With no ready, outputs hold stable.
- Latency:
  - A last completion sampled at edge t gives commit_valid_o in the cycle after edge t.
  - Dispatch of a last micro-op to its completion takes at least one cycle.
  - There is no zero-latency bypass.
- Simultaneous retire and dispatch in one cycle are both honoured. count_o updates by (+1 if a new entry opens) minus retired.
- flush_i: at the next edge, same state as reset, including sticky flags. It overrides push, completion and retire in that cycle.
- Reset mid-operation: immediate clear. Later completions are treated as underflow.
- Wrap-around: pointer wrap bits distinguish full from empty. Tag FIFOs wrap independently at UOP_DEPTH.

Test Plan:
- Reset, then 3 single-uop instructions (IDs 1,2,3) to queue 0, completing in order with ready=1 → commits 1,2,3, no more than 2 lanes per cycle, count_o returns to 0.
- Instruction A (ID 5) = uops on q1,q2; instruction B (ID 6) = one uop on q3. q3 completes first, then q1, then q2 → B held until A done; then lanes 0/1 = 5/6 in the same cycle.
- Open 8 instructions with ready=0, all completed → full_o=1, commit_valid_o=2'b11 held stable. A 9th push sets overflow_o=1 and is dropped. Ready=1 drains 8 IDs in 4 cycles with correct wrap order.
- queues_done_i[2] pulsed with q2 empty → underflow_o=1, no state change. Flush → both flags 0, count_o=0.
- Same-cycle completion on q0 and q1 for one entry holding 2 pending, plus a dispatch of that entry's last uop → pending goes 2→1. The entry commits only after the new uop completes.
- Assert arsn_i low mid-stream with 4 entries pending → all outputs 0 immediately. Operation after release restarts with head=0.
